// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller slice.
// Holds the FSM state encoding, register word addresses and the bit
// positions of the CTRL and STATUS fields.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } timer_state_e;

    // Plain constants for the state register, same encoding as the enum.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Register word addresses.
    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_PSC    = 2;
    localparam int ADDR_ARR    = 3;
    localparam int ADDR_CNT    = 4;

    // CTRL bit positions.
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_OPM    = 2;
    localparam int CTRL_UG     = 3;

    // STATUS bit positions.
    localparam int STATUS_UIF  = 0;

endpackage

// File: rtl/timer_ctrl_regs.sv
// Register file for the timer controller.
// Holds CTRL (EN/IRQ_EN/OPM), STATUS.UIF (write-1-to-clear), and the
// preload PSC/ARR values, and produces the registered read data.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   wen, ren, addr    bus strobes and word address
//   wdata             write data
//   tcnt              live count, returned on CNT reads
//   uif_set           wrap detected this cycle (sets UIF)
//   en_clr            clear CTRL.EN this cycle (one-pulse completion)
//   rdata, rvalid     registered read data / valid
//   ctrl_en, ctrl_irq_en, ctrl_opm, uif   current field values
//   psc_pre, arr_pre  preload values applied by the sequencer
module timer_ctrl_regs
    import timer_pkg::*;
#(
    parameter int BITS_WIDTH = 32,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [BITS_WIDTH-1:0] wdata,
    input  logic [BITS_WIDTH-1:0] tcnt,
    input  logic                  uif_set,
    input  logic                  en_clr,
    output logic [BITS_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  ctrl_en,
    output logic                  ctrl_irq_en,
    output logic                  ctrl_opm,
    output logic                  uif,
    output logic [BITS_WIDTH-1:0] psc_pre,
    output logic [BITS_WIDTH-1:0] arr_pre
);

    localparam int NUM_ADDR = 1 << ADDR_W;

    logic [NUM_ADDR-1:0]   wr_hit;
    logic                  ctrl_en_reg, ctrl_en_next;
    logic                  ctrl_irq_en_reg, ctrl_irq_en_next;
    logic                  ctrl_opm_reg, ctrl_opm_next;
    logic                  uif_reg, uif_next;
    logic [BITS_WIDTH-1:0] psc_reg, psc_next;
    logic [BITS_WIDTH-1:0] arr_reg, arr_next;
    logic [BITS_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  rvalid_reg;

    // One write-enable per word address; reserved addresses simply have
    // no register attached to their hit line.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ADDR; gi++) begin : g_wr_hit
            assign wr_hit[gi] = wen && (addr == ADDR_W'(gi));
        end
    endgenerate

    always_comb begin
        ctrl_en_next     = ctrl_en_reg;
        ctrl_irq_en_next = ctrl_irq_en_reg;
        ctrl_opm_next    = ctrl_opm_reg;
        if (wr_hit[ADDR_CTRL]) begin
            ctrl_en_next     = wdata[CTRL_EN];
            ctrl_irq_en_next = wdata[CTRL_IRQ_EN];
            ctrl_opm_next    = wdata[CTRL_OPM];
        end
        // One-pulse completion overrides a concurrent CTRL write.
        if (en_clr) begin
            ctrl_en_next = 1'b0;
        end

        // A new wrap beats a simultaneous clear so no event is lost.
        uif_next = uif_reg;
        if (wr_hit[ADDR_STATUS] && wdata[STATUS_UIF]) begin
            uif_next = 1'b0;
        end
        if (uif_set) begin
            uif_next = 1'b1;
        end

        psc_next = wr_hit[ADDR_PSC] ? wdata : psc_reg;

        // ARR of zero would make the wrap condition unreachable.
        arr_next = arr_reg;
        if (wr_hit[ADDR_ARR]) begin
            arr_next = (wdata == '0) ? BITS_WIDTH'(1) : wdata;
        end

        // Read mux sees pre-edge values, so a same-cycle write is not
        // visible in the data returned for this read.
        rdata_next = rdata_reg;
        if (ren) begin
            rdata_next = '0;
            case (addr)
                ADDR_W'(ADDR_CTRL): begin
                    rdata_next[CTRL_EN]     = ctrl_en_reg;
                    rdata_next[CTRL_IRQ_EN] = ctrl_irq_en_reg;
                    rdata_next[CTRL_OPM]    = ctrl_opm_reg;
                end
                ADDR_W'(ADDR_STATUS): rdata_next[STATUS_UIF] = uif_reg;
                ADDR_W'(ADDR_PSC):    rdata_next = psc_reg;
                ADDR_W'(ADDR_ARR):    rdata_next = arr_reg;
                ADDR_W'(ADDR_CNT):    rdata_next = tcnt;
                default:              rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en_reg     <= 1'b0;
            ctrl_irq_en_reg <= 1'b0;
            ctrl_opm_reg    <= 1'b0;
            uif_reg         <= 1'b0;
            psc_reg         <= '0;
            arr_reg         <= '1;
            rdata_reg       <= '0;
            rvalid_reg      <= 1'b0;
        end else begin
            ctrl_en_reg     <= ctrl_en_next;
            ctrl_irq_en_reg <= ctrl_irq_en_next;
            ctrl_opm_reg    <= ctrl_opm_next;
            uif_reg         <= uif_next;
            psc_reg         <= psc_next;
            arr_reg         <= arr_next;
            rdata_reg       <= rdata_next;
            rvalid_reg      <= ren;
        end
    end

    assign ctrl_en     = ctrl_en_reg;
    assign ctrl_irq_en = ctrl_irq_en_reg;
    assign ctrl_opm    = ctrl_opm_reg;
    assign uif         = uif_reg;
    assign psc_pre     = psc_reg;
    assign arr_pre     = arr_reg;
    assign rdata       = rdata_reg;
    assign rvalid      = rvalid_reg;

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller top: sequences one time_base counter channel.
// Runs the IDLE/START/RUN/DONE machine, detects wrap from the returned
// count, applies preload PSC/ARR at start and at wrap, and raises a
// registered level interrupt.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   wen, ren, addr, wdata register bus; rdata/rvalid registered read
//   tcnt                  count returned by time_base
//   tc_en/nxt_tc_en       counter enable (registered / D input)
//   tc_rst/nxt_tc_rst     counter sync clear (registered / D input)
//   tc_irq_en/nxt_tc_irq_en  CTRL.IRQ_EN mirror (registered / D input)
//   tarr, tpsc            active autoreload and prescaler
//   irq                   STATUS.UIF & CTRL.IRQ_EN, registered
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int BITS_WIDTH = 32,
    parameter int MAX_BIT    = BITS_WIDTH - 1,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic              ren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [MAX_BIT:0]  wdata,
    output logic [MAX_BIT:0]  rdata,
    output logic              rvalid,
    input  logic [MAX_BIT:0]  tcnt,
    output logic              tc_en,
    output logic              nxt_tc_en,
    output logic              tc_rst,
    output logic              nxt_tc_rst,
    output logic              tc_irq_en,
    output logic              nxt_tc_irq_en,
    output logic [MAX_BIT:0]  tarr,
    output logic [MAX_BIT:0]  tpsc,
    output logic              irq
);

    logic [1:0]       state_reg, state_next;
    logic [MAX_BIT:0] prev_tcnt_reg, prev_tcnt_next;
    logic [MAX_BIT:0] tarr_reg, tarr_next;
    logic [MAX_BIT:0] tpsc_reg, tpsc_next;
    logic             tc_en_reg, tc_en_next;
    logic             tc_rst_reg, tc_rst_next;
    logic             tc_irq_en_reg, tc_irq_en_next;
    logic             irq_reg, irq_next;

    logic             ctrl_en, ctrl_irq_en, ctrl_opm, uif;
    logic [MAX_BIT:0] psc_pre, arr_pre;
    logic             ctrl_wr, en_wr0, en_wr1, ug_wr, wrap, en_clr;

    timer_ctrl_regs #(
        .BITS_WIDTH (BITS_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .ren         (ren),
        .addr        (addr),
        .wdata       (wdata),
        .tcnt        (tcnt),
        .uif_set     (wrap),
        .en_clr      (en_clr),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .ctrl_en     (ctrl_en),
        .ctrl_irq_en (ctrl_irq_en),
        .ctrl_opm    (ctrl_opm),
        .uif         (uif),
        .psc_pre     (psc_pre),
        .arr_pre     (arr_pre)
    );

    // CTRL write decode used by the sequencer; the write lands on the
    // same edge as the resulting state change.
    assign ctrl_wr = wen && (addr == ADDR_W'(ADDR_CTRL));
    assign en_wr0  = ctrl_wr && !wdata[CTRL_EN];
    assign en_wr1  = ctrl_wr && wdata[CTRL_EN] && !ctrl_en;
    assign ug_wr   = ctrl_wr && wdata[CTRL_UG];

    // Wrap: the previous sample sat at the reload value and the counter
    // has now returned to zero.
    assign wrap = (state_reg == ST_RUN) && (prev_tcnt_reg == tarr_reg) && (tcnt == '0);

    always_comb begin
        state_next     = state_reg;
        prev_tcnt_next = prev_tcnt_reg;
        tarr_next      = tarr_reg;
        tpsc_next      = tpsc_reg;
        tc_en_next     = 1'b0;
        tc_rst_next    = 1'b0;
        en_clr         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (en_wr1) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                tc_rst_next    = 1'b1;
                tarr_next      = arr_pre;
                tpsc_next      = psc_pre;
                prev_tcnt_next = '0;
                state_next     = ST_RUN;
            end
            ST_RUN: begin
                tc_en_next     = 1'b1;
                prev_tcnt_next = tcnt;
                if (wrap) begin
                    tarr_next = arr_pre;
                    tpsc_next = psc_pre;
                end
                // Stop beats restart; restart beats one-pulse completion.
                if (en_wr0) begin
                    state_next = ST_IDLE;
                end else if (ug_wr) begin
                    state_next = ST_START;
                end else if (wrap && ctrl_opm) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                en_clr     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        tc_irq_en_next = ctrl_irq_en;
        irq_next       = uif && ctrl_irq_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            prev_tcnt_reg <= '0;
            tarr_reg      <= '1;
            tpsc_reg      <= '0;
            tc_en_reg     <= 1'b0;
            tc_rst_reg    <= 1'b0;
            tc_irq_en_reg <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prev_tcnt_reg <= prev_tcnt_next;
            tarr_reg      <= tarr_next;
            tpsc_reg      <= tpsc_next;
            tc_en_reg     <= tc_en_next;
            tc_rst_reg    <= tc_rst_next;
            tc_irq_en_reg <= tc_irq_en_next;
            irq_reg       <= irq_next;
        end
    end

    assign tc_en         = tc_en_reg;
    assign nxt_tc_en     = tc_en_next;
    assign tc_rst        = tc_rst_reg;
    assign nxt_tc_rst    = tc_rst_next;
    assign tc_irq_en     = tc_irq_en_reg;
    assign nxt_tc_irq_en = tc_irq_en_next;
    assign tarr          = tarr_reg;
    assign tpsc          = tpsc_reg;
    assign irq           = irq_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with a time_base counter model.
module tb_timer_ctrl;

    localparam int BW = 32;
    localparam int AW = 3;
    localparam logic [AW-1:0] A_CTRL   = 3'd0;
    localparam logic [AW-1:0] A_STATUS = 3'd1;
    localparam logic [AW-1:0] A_PSC    = 3'd2;
    localparam logic [AW-1:0] A_ARR    = 3'd3;
    localparam logic [AW-1:0] A_CNT    = 3'd4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wen = 1'b0;
    logic          ren = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [BW-1:0] wdata = '0;
    logic [BW-1:0] rdata, tarr, tpsc;
    logic [BW-1:0] tcnt = '0;
    logic [BW-1:0] psc_cnt = '0;
    logic          rvalid, tc_en, nxt_tc_en, tc_rst, nxt_tc_rst;
    logic          tc_irq_en, nxt_tc_irq_en, irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    timer_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .wen           (wen),
        .ren           (ren),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .tcnt          (tcnt),
        .tc_en         (tc_en),
        .nxt_tc_en     (nxt_tc_en),
        .tc_rst        (tc_rst),
        .nxt_tc_rst    (nxt_tc_rst),
        .tc_irq_en     (tc_irq_en),
        .nxt_tc_irq_en (nxt_tc_irq_en),
        .tarr          (tarr),
        .tpsc          (tpsc),
        .irq           (irq)
    );

    // time_base plant: prescaled up-counter wrapping after tarr.
    always @(posedge clk) begin
        if (rst || tc_rst) begin
            tcnt    <= '0;
            psc_cnt <= '0;
        end else if (tc_en) begin
            if (psc_cnt >= tpsc) begin
                psc_cnt <= '0;
                tcnt    <= (tcnt >= tarr) ? '0 : tcnt + 32'd1;
            end else begin
                psc_cnt <= psc_cnt + 32'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
        wen = 1'b1; addr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [BW-1:0] d, output logic v);
        ren = 1'b1; addr = a;
        tick();
        ren = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    task automatic test_reset();
        logic [BW-1:0] d;
        logic          v;
        logic [BW-1:0] exp_rd [5];
        logic [AW-1:0] a;
        do_reset();
        $display("reset: checking outputs");
        total++; if (tc_en !== 1'b0) begin bad++; $display("FAIL reset_tc_en got=%0b want=0", tc_en); end
        total++; if (tc_rst !== 1'b0 || nxt_tc_rst !== 1'b0) begin bad++; $display("FAIL reset_tc_rst got=%0b/%0b want=0/0", tc_rst, nxt_tc_rst); end
        total++; if (nxt_tc_en !== 1'b0) begin bad++; $display("FAIL reset_nxt_tc_en got=%0b want=0", nxt_tc_en); end
        total++; if (tc_irq_en !== 1'b0 || nxt_tc_irq_en !== 1'b0) begin bad++; $display("FAIL reset_irq_en got=%0b/%0b want=0/0", tc_irq_en, nxt_tc_irq_en); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b want=0", irq); end
        total++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL reset_rd got=%0b/%0h want=0/0", rvalid, rdata); end
        total++; if (tarr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_tarr got=%0h want=ffffffff", tarr); end
        total++; if (tpsc !== 32'h0) begin bad++; $display("FAIL reset_tpsc got=%0h want=0", tpsc); end
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; exp_rd[2] = 32'h0;
        exp_rd[3] = 32'hFFFF_FFFF; exp_rd[4] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            a = AW'(i);
            rd(a, d, v);
            $display("reset: read addr=%0d data=%0h", i, d);
            total++; if (v !== 1'b1 || d !== exp_rd[i]) begin bad++; $display("FAIL reset_read%0d got=%0b/%0h want=1/%0h", i, v, d, exp_rd[i]); end
        end
    endtask

    // Randomised runs: the expected timeline follows from the latencies
    // (tc_rst at edge 2, tc_en from edge 3, count n reached at edge
    // 3+(psc+1)*n, UIF one edge after the wrap, irq one edge later).
    task automatic test_run(input int trials);
        for (int t = 0; t < trials; t++) begin
            int            psc, arr, opm, ie, ew;
            logic [BW-1:0] ctrl, d, exp_ctrl, exp_cnt;
            logic          v, exp_en, exp_irq;
            psc = int'($urandom_range(0, 2));
            arr = int'($urandom_range(1, 4));
            opm = int'($urandom_range(0, 1));
            ie  = int'($urandom_range(0, 1));
            ew  = 3 + (psc + 1) * (arr + 1);
            ctrl = 32'(1 + 2 * ie + 4 * opm);
            do_reset();
            wr(A_PSC, 32'(psc));
            wr(A_ARR, 32'(arr));
            $display("run: psc=%0d arr=%0d opm=%0d irq_en=%0d", psc, arr, opm, ie);
            wr(A_CTRL, ctrl);
            for (int k = 1; k <= ew + 2; k++) begin
                if (k > 1) tick();
                exp_en  = (k >= 3) && !(opm == 1 && k >= ew + 2);
                exp_irq = (ie == 1) && (k >= ew + 2);
                total++; if (tc_en !== exp_en) begin bad++; $display("FAIL run_tc_en k=%0d got=%0b want=%0b", k, tc_en, exp_en); end
                total++; if (tc_rst !== (k == 2)) begin bad++; $display("FAIL run_tc_rst k=%0d got=%0b want=%0b", k, tc_rst, (k == 2)); end
                total++; if (irq !== exp_irq) begin bad++; $display("FAIL run_irq k=%0d got=%0b want=%0b", k, irq, exp_irq); end
                total++; if (tc_irq_en !== (ie == 1 && k >= 2)) begin bad++; $display("FAIL run_tc_irq_en k=%0d got=%0b want=%0b", k, tc_irq_en, (ie == 1 && k >= 2)); end
                if (k >= 2) begin
                    total++; if (tarr !== 32'(arr) || tpsc !== 32'(psc)) begin bad++; $display("FAIL run_active k=%0d got=%0h/%0h want=%0h/%0h", k, tarr, tpsc, arr, psc); end
                end
                if (k >= 3) begin
                    exp_cnt = 32'(((k - 3) / (psc + 1)) % (arr + 1));
                    total++; if (tcnt !== exp_cnt) begin bad++; $display("FAIL run_tcnt k=%0d got=%0h want=%0h", k, tcnt, exp_cnt); end
                end
            end
            rd(A_STATUS, d, v);
            total++; if (d !== 32'h1) begin bad++; $display("FAIL run_uif got=%0h want=1", d); end
            rd(A_CTRL, d, v);
            exp_ctrl = (opm == 1) ? (ctrl & 32'hFFFF_FFFE) : ctrl;
            total++; if (d !== exp_ctrl) begin bad++; $display("FAIL run_ctrl got=%0h want=%0h", d, exp_ctrl); end
        end
    endtask

    task automatic test_regs();
        logic [BW-1:0] d, val, prev_val, exp_arr;
        logic          v;
        logic [AW-1:0] a;
        do_reset();
        prev_val = '0;
        for (int i = 0; i < 4; i++) begin
            val = $urandom;
            wr(A_PSC, val);
            rd(A_PSC, d, v);
            $display("regs: psc wrote=%0h read=%0h", val, d);
            total++; if (d !== val) begin bad++; $display("FAIL regs_psc got=%0h want=%0h", d, val); end
            prev_val = val;
            val = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            exp_arr = (val == 32'h0) ? 32'h1 : val;
            wr(A_ARR, val);
            rd(A_ARR, d, v);
            $display("regs: arr wrote=%0h read=%0h", val, d);
            total++; if (d !== exp_arr) begin bad++; $display("FAIL regs_arr got=%0h want=%0h", d, exp_arr); end
        end
        // Same-cycle write and read returns the old value.
        val = ~prev_val;
        wen = 1'b1; ren = 1'b1; addr = A_PSC; wdata = val;
        tick();
        wen = 1'b0; ren = 1'b0;
        $display("regs: same-cycle wr/rd data=%0h", rdata);
        total++; if (rdata !== prev_val) begin bad++; $display("FAIL regs_wr_rd got=%0h want=%0h", rdata, prev_val); end
        rd(A_PSC, d, v);
        total++; if (d !== val) begin bad++; $display("FAIL regs_wr_rd_after got=%0h want=%0h", d, val); end
        for (int i = 5; i < 8; i++) begin
            a = AW'(i);
            wr(a, $urandom);
            rd(a, d, v);
            $display("regs: reserved addr=%0d read=%0h", i, d);
            total++; if (d !== 32'h0) begin bad++; $display("FAIL regs_reserved%0d got=%0h want=0", i, d); end
        end
        // UG is write-only and must not start the timer from IDLE.
        wr(A_CTRL, 32'hE);
        rd(A_CTRL, d, v);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL regs_ctrl_ug got=%0h want=6", d); end
        total++; if (nxt_tc_rst !== 1'b0) begin bad++; $display("FAIL regs_ug_idle got=%0b want=0", nxt_tc_rst); end
        rd(A_CNT, d, v);
        total++; if (d !== tcnt) begin bad++; $display("FAIL regs_cnt got=%0h want=%0h", d, tcnt); end
    endtask

    task automatic test_preload();
        logic [BW-1:0] d;
        logic          v;
        do_reset();
        wr(A_PSC, 32'h0);
        wr(A_ARR, 32'h3);
        wr(A_CTRL, 32'h3);            // edge 1
        tick(); tick(); tick();       // edge 4
        wr(A_ARR, 32'h5);             // edge 5; wrap lands at edge 7
        for (int k = 5; k <= 8; k++) begin
            if (k > 5) tick();
            total++;
            if (tarr !== ((k == 8) ? 32'h5 : 32'h3)) begin
                bad++; $display("FAIL preload_tarr k=%0d got=%0h want=%0h", k, tarr, (k == 8) ? 32'h5 : 32'h3);
            end
        end
        $display("preload: tarr after wrap=%0h", tarr);
        rd(A_ARR, d, v);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL preload_arr_rd got=%0h want=5", d); end
        wr(A_ARR, 32'h0);
        rd(A_ARR, d, v);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL preload_arr0 got=%0h want=1", d); end
    endtask

    task automatic test_w1c();
        logic [BW-1:0] d;
        logic          v;
        do_reset();
        wr(A_PSC, 32'h0);
        wr(A_ARR, 32'h1);
        wr(A_CTRL, 32'h3);            // edge 1; wraps seen after edges 5,7,9
        for (int i = 0; i < 6; i++) tick();   // edge 7
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_first got=%0b want=1", irq); end
        wen = 1'b1; addr = A_STATUS; wdata = 32'h1;
        tick();                       // edge 8: clear collides with a wrap
        wen = 1'b0;
        rd(A_STATUS, d, v);           // edge 9
        $display("w1c: collide status=%0h irq=%0b", d, irq);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL w1c_collide_uif got=%0h want=1", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_collide_irq got=%0b want=1", irq); end
        wr(A_CTRL, 32'h2);            // stop, coincides with a wrap
        total++; if (nxt_tc_en !== 1'b0) begin bad++; $display("FAIL w1c_stop got=%0b want=0", nxt_tc_en); end
        tick(); tick();
        wr(A_STATUS, 32'h1);
        tick();
        $display("w1c: after clear irq=%0b", irq);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_clear got=%0b want=0", irq); end
        rd(A_STATUS, d, v);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_uif_clear got=%0h want=0", d); end
    endtask

    task automatic test_reset_midrun();
        logic [BW-1:0] d;
        logic          v;
        int            n;
        do_reset();
        wr(A_PSC, 32'h0);
        wr(A_ARR, 32'h4);
        wr(A_CTRL, 32'h3);
        n = 0;
        while (tcnt !== 32'h2 && n < 20) begin
            tick();
            n++;
        end
        total++; if (tcnt !== 32'h2) begin bad++; $display("FAIL midrun_wait got=%0h want=2", tcnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("midrun: reset applied tc_en=%0b irq=%0b", tc_en, irq);
        total++; if (tc_en !== 1'b0 || nxt_tc_en !== 1'b0) begin bad++; $display("FAIL midrun_en got=%0b/%0b want=0/0", tc_en, nxt_tc_en); end
        total++; if (tc_rst !== 1'b0 || tc_irq_en !== 1'b0) begin bad++; $display("FAIL midrun_rst_irqen got=%0b/%0b want=0/0", tc_rst, tc_irq_en); end
        total++; if (tarr !== 32'hFFFF_FFFF || tpsc !== 32'h0) begin bad++; $display("FAIL midrun_active got=%0h/%0h want=ffffffff/0", tarr, tpsc); end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (irq !== 1'b0 || tc_en !== 1'b0) begin bad++; $display("FAIL midrun_idle i=%0d irq=%0b tc_en=%0b want=0/0", i, irq, tc_en); end
        end
        rd(A_CTRL, d, v);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midrun_ctrl got=%0h want=0", d); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_run(6);
        test_preload();
        test_w1c();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Register-mapped controller that configures and sequences one time_base counter channel.
- Holds CTRL, STATUS, PSC and ARR registers, with preload (shadow) PSC/ARR applied at counter wrap.
- Runs a start/run/stop/one-pulse state machine and drives time_base's registered and next-value control inputs.
- Detects wrap from the returned count and raises a level interrupt toward the system interrupt controller.

Parameters:
- BITS_WIDTH, 32, width of count, prescaler, autoreload and bus data.
- MAX_BIT, BITS_WIDTH-1, MSB index.
- ADDR_W, 3, register word-address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wen  in  1  register write strobe.
- ren  in  1  register read strobe.
- addr  in  ADDR_W  word address: 0 CTRL, 1 STATUS, 2 PSC, 3 ARR, 4 CNT; others reserved.
- wdata  in  BITS_WIDTH  write data.
- rdata  out  BITS_WIDTH  read data, registered.
- rvalid  out  1  read data valid, one cycle after ren.
- tcnt  in  BITS_WIDTH  current count from time_base.
- tc_en, nxt_tc_en  out  1  counter enable, registered and next value.
- tc_rst, nxt_tc_rst  out  1  counter sync clear, registered and next value.
- tc_irq_en, nxt_tc_irq_en  out  1  mirrors CTRL.IRQ_EN, registered and next value.
- tarr  out  BITS_WIDTH  active autoreload value.
- tpsc  out  BITS_WIDTH  active prescaler value.
- irq  out  1  level interrupt = STATUS.UIF & CTRL.IRQ_EN, registered.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; CTRL=0, STATUS=0, preload PSC=0, preload ARR=all ones; tarr=all ones, tpsc=0; all tc_* outputs 0; irq=0, rdata=0, rvalid=0, prev_tcnt=0. Reset mid-run aborts immediately with no wrap or irq.
- Every nxt_* output is the combinational D input of its tc_* register, so nxt_X equals X one cycle later.
- CTRL bits:
  - [0] EN.
  - [1] IRQ_EN.
  - [2] OPM (one-pulse mode).
  - [3] UG (update generate): write-only, reads 0, self-clearing.
  - Other bits read 0.
- Write timing: writes take effect on the same edge.
- ARR writes of 0 are stored as 1, because wrap is undetectable with ARR=0.
- STATUS[0] UIF is write-1-to-clear. If set and clear happen in the same cycle, set wins.
- State IDLE: nxt_tc_en=0.
  - EN written 0->1 -> START.
- State START (exactly 1 cycle):
  - nxt_tc_rst=1.
  - tarr/tpsc load from preload.
  - prev_tcnt cleared.
  - Next state RUN.
- State RUN: nxt_tc_en=1.
  - EN written 0 -> IDLE. The count holds, and the next start clears it.
  - UG written 1 -> START (restart and reload).
- Wrap event (RUN only): prev_tcnt == tarr and tcnt == 0. On the wrap cycle:
  - set UIF;
  - load preload PSC/ARR into tpsc/tarr (new values used from the next edge);
  - if OPM=1 -> DONE.
- State DONE (1 cycle): nxt_tc_en=0, CTRL.EN cleared -> IDLE.
- Simultaneous events:
  - EN=0 write and wrap in the same cycle: UIF is still set, next state IDLE.
  - UG and wrap in the same cycle: UG wins (START); UIF is still set.
- prev_tcnt <= tcnt every cycle in RUN.
- Read path: rdata/rvalid are registered. Same-cycle write and read to the same address returns the old value. CNT returns tcnt sampled at the ren cycle. Reserved addresses read 0 and ignore writes.
- Latencies:
  - EN write -> tc_rst high on the second edge;
  - tc_en high on the third edge;
  - wrap -> irq high one edge after UIF sets.

Decomposition:
- Package timer_pkg holds:
  - state enum {IDLE, START, RUN, DONE};
  - register address localparams;
  - CTRL/STATUS bit-index constants.
- One natural sub-module, timer_ctrl_regs: register file, W1C logic, preload registers and read mux.
- The state machine, wrap detect and tc_* drive stay in timer_ctrl.

Test Plan:
- Reset, then read all registers -> CTRL=0, STATUS=0, PSC=0, ARR=0xFFFFFFFF; all outputs 0.
- PSC=1, ARR=3, write CTRL=0x3 with a time_base model attached -> one cycle tc_rst, then tc_en=1; tcnt 0,1,2,3,0; UIF=1 and irq=1 at the wrap.
- Same setup with OPM: CTRL=0x7 -> exactly one wrap, tc_en drops, CTRL reads 0x6, state IDLE.
- While running with ARR=3, write ARR=5 -> tarr stays 3 until the next wrap, then 5. Write ARR=0 -> reads back 1.
- UIF=1, then write STATUS=1 in the same cycle as a wrap -> UIF remains 1. Write STATUS=1 later -> UIF=0, irq=0.
- Assert rst while in RUN with tcnt=2 -> next cycle all outputs 0, state IDLE, no irq.
